// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src', 00..9F} into OAM, one byte per CPU M-cycle,
// and arbitrates the CPU's bus access while a transfer runs. Build option: OAM_DMA_READBACK_EN.
`timescale 1ns/1ps

module oam_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_dout,
  output logic        oam_wr,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, ARMED, START, ACTIVE} state_t;

  state_t      state, state_nx;
  logic        phi_q;
  logic [1:0]  phase_q, phase;
  logic [7:0]  src;      // doubles as the FF46 register: both load cpu_dout together and reset to FF
  logic [7:0]  idx;
  logic [7:0]  data_q;
  logic [7:0]  src_eff;
  logic        ff46_wr, ff46_rd, hram, cpu_ok, dma_rd, last_byte;

  // The T0 clk itself reads as phase 0, so state changes made at the T3 edge land exactly on T0.
  assign phase      = (phi && !phi_q) ? 2'd0 : phase_q;
  assign ff46_wr    = cpu_wr && (cpu_a == 16'hFF46);
  assign hram       = (cpu_a[15:7] == 9'h1FF) && (cpu_a != 16'hFFFF);
  assign dma_active = (state == START) || (state == ACTIVE);
  assign src_eff    = (src >= 8'hE0) ? src - 8'h20 : src;
  // oam_wr of byte 159 is visible in the clk after its T3; the transfer ends after that clk.
  assign last_byte  = (state == ACTIVE) && oam_wr && (oam_a == 8'd159);
  assign dma_rd     = (state == ACTIVE) && (phase != 2'd3) && !last_byte;
  assign cpu_ok     = !dma_active ||
                      (hram && ((state == START) || ((state == ACTIVE) && (phase == 2'd3))));

`ifdef OAM_DMA_READBACK_EN
  assign ff46_rd = cpu_rd && (cpu_a == 16'hFF46);
`else
  assign ff46_rd = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      ARMED:   if (phase == 2'd3) state_nx = START;
      START:   if (phase == 2'd3) state_nx = ACTIVE;
      ACTIVE:  if (last_byte)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (ff46_wr) state_nx = ARMED;
  end

  always_comb begin
    mem_a    = cpu_a;
    mem_dout = cpu_dout;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    cpu_din  = 8'hFF;
    if ((state == ACTIVE) && (phase != 2'd3)) begin
      mem_a  = {src_eff, idx};
      mem_rd = dma_rd;
    end else if (cpu_ok) begin
      mem_rd  = cpu_rd && !ff46_rd;
      mem_wr  = cpu_wr;
      cpu_din = mem_din;
    end
    if (ff46_rd) cpu_din = src;
  end

  // NOTE: every datapath flop is reset here; the block holds no memory array needing exemption.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi_q    <= 1'b0;
      phase_q  <= 2'd0;
      src      <= 8'hFF;
      idx      <= 8'd0;
      data_q   <= 8'd0;
      oam_wr   <= 1'b0;
      oam_a    <= 8'd0;
      oam_dout <= 8'd0;
    end else begin
      phi_q   <= phi;
      phase_q <= phase + 2'd1;
      oam_wr  <= 1'b0;
      if (ff46_wr) begin
        src <= cpu_dout;
        idx <= 8'd0;
      end else if (state == ACTIVE) begin
        if (phase == 2'd2) data_q <= mem_din;
        if (phase == 2'd3) begin
          oam_wr   <= 1'b1;
          oam_a    <= idx;
          oam_dout <= data_q;
          if (idx != 8'd159) idx <= idx + 8'd1;
        end
        if (last_byte) idx <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: idle pass-through table, whole transfers against a
// page-copy model, randomized CPU traffic against an M-cycle window model, restart and reset.
`timescale 1ns/1ps

module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst, phi, cpu_rd, cpu_wr, mem_rd, mem_wr, oam_wr, dma_active;
  logic [15:0] cpu_a, mem_a;
  logic [7:0]  cpu_dout, cpu_din, mem_dout, mem_din, oam_a, oam_dout;

  logic [7:0]  mem [0:65535];
  assign mem_din = mem[mem_a];

  oam_dma dut (
    .clk(clk), .rst(rst), .phi(phi),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .oam_a(oam_a), .oam_dout(oam_dout), .oam_wr(oam_wr), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ph = 3, cyc = 0;

  // Observations gathered by the monitor since the last clr_mon().
  logic [7:0]  oam_img [0:159];
  int          oam_cnt, first_wr, act_t0, dma_wr_bad, oam_oob;
  logic [15:0] rd_q [$];

  typedef struct {
    logic [15:0] a;
    logic [7:0]  dout;
    logic        rd, wr;
    logic [15:0] exp_a;
    logic        exp_rd, exp_wr;
    logic [7:0]  exp_din, exp_dout;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    ph  = (ph + 1) % 4;
    phi = (ph < 2);
    cyc++;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_dout = 8'h00;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic clr_mon();
    for (int i = 0; i < 160; i++) oam_img[i] = 'x;
    oam_cnt = 0; first_wr = -1; act_t0 = 0; dma_wr_bad = 0; oam_oob = 0;
    rd_q.delete();
  endtask

  task automatic ff46_write(input logic [7:0] v, input int p, output int cw);
    tick();
    for (int i = 0; i < 4 && ph != p; i++) tick();
    cpu_a = 16'hFF46; cpu_dout = v; cpu_wr = 1'b1;
    cw = cyc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (oam_wr) begin
        if (oam_a < 8'd160) oam_img[oam_a] = oam_dout;
        else oam_oob++;
        oam_cnt++;
        if (first_wr < 0) first_wr = cyc;
      end
      if (ph == 0 && dma_active) act_t0++;
      if (ph == 2 && dma_active && mem_rd) rd_q.push_back(mem_a);
      if (mem_wr && !cpu_wr) dma_wr_bad++;
    end
  end

  // Expected transfer result: OAM[i] = mem[{src', i}], first write 3 M-cycles after the write's T0.
  task automatic verify(input string tag, input logic [7:0] s, input int t0w);
    logic [7:0] sp = (s >= 8'hE0) ? s - 8'h20 : s;
    int bad = 0, sweep_bad = 0;
    check({tag, "_first_oam_wr"}, first_wr - t0w, 12);
    check({tag, "_oam_wr_count"}, oam_cnt, 160);
    check({tag, "_active_mcycles"}, act_t0, 162);
    check({tag, "_active_end"}, dma_active, 1'b0);
    for (int i = 0; i < 160; i++)
      if (oam_img[i] !== mem[{sp, 8'(i)}]) bad++;
    check({tag, "_oam_bytes_bad"}, bad, 0);
    check({tag, "_dma_reads"}, rd_q.size(), 160);
    if (rd_q.size() > 0) check({tag, "_first_read"}, rd_q[0], {sp, 8'h00});
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== {sp, 8'(i)}) sweep_bad++;
    check({tag, "_sweep_bad"}, sweep_bad, 0);
    check({tag, "_dma_mem_wr"}, dma_wr_bad, 0);
    check({tag, "_oam_index_range"}, oam_oob, 0);
  endtask

  // Random CPU access judged by its position in the transfer window (write at T0 of M-cycle 0).
  task automatic rnd_cpu(input int cw);
    int m = (cyc - cw) / 4;
    int p = ph;
    bit act    = (m >= 1 && m <= 161) || (m == 162 && p == 0);
    bit act_st = (m >= 2 && m <= 161) || (m == 162 && p == 0);
    int r = $urandom_range(0, 3);
    logic [15:0] a;
    logic [7:0]  d = 8'($urandom);
    bit hr, pass;
    case ($urandom_range(0, 3))
      0:       a = 16'hFF80 + 16'($urandom_range(0, 126));
      1:       a = 16'h8000 + 16'($urandom_range(0, 8191));
      2:       a = 16'hC000 + 16'($urandom_range(0, 4095));
      default: a = 16'hFFFF;
    endcase
    hr   = (a >= 16'hFF80) && (a <= 16'hFFFE);
    pass = !act || (hr && (m == 1 || (act_st && p == 3)));
    if (p != 2 && r == 0) begin
      cpu_rd = 1'b1; cpu_a = a;
      @(negedge clk);
      check("rnd_rd_din", cpu_din, pass ? mem[a] : 8'hFF);
      if (pass) check("rnd_rd_addr", mem_a, a);
    end else if (p == 1 && r == 1) begin
      cpu_wr = 1'b1; cpu_a = a; cpu_dout = d;
      @(negedge clk);
      check("rnd_wr_strobe", mem_wr, pass);
      if (pass) check("rnd_wr_data", {mem_a, mem_dout}, {a, d});
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int cw, cw2, act_base;
    logic [7:0] s;
    rst = 1'b1; phi = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_dout = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    mem[16'h8000] = 8'hAB; mem[16'hC000] = 8'h11; mem[16'hFF90] = 8'h77;
    mem[16'hFFFF] = 8'hEE; mem[16'hFF46] = 8'h5C;
    clr_mon();

    vecs[0] = '{16'h8000, 8'h00, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 8'hAB, 8'h00};
    vecs[1] = '{16'hC000, 8'h33, 1'b0, 1'b1, 16'hC000, 1'b0, 1'b1, 8'h11, 8'h33};
    vecs[2] = '{16'hFF90, 8'h00, 1'b1, 1'b0, 16'hFF90, 1'b1, 1'b0, 8'h77, 8'h00};
    vecs[3] = '{16'hFFFF, 8'h9C, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 8'hEE, 8'h9C};
`ifdef OAM_DMA_READBACK_EN
    vecs[4] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 16'hFF46, 1'b0, 1'b0, 8'hFF, 8'h00};
`else
    vecs[4] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 16'hFF46, 1'b1, 1'b0, 8'h5C, 8'h00};
`endif

    repeat (4) tick();
    @(negedge clk);
    check("reset_dma_active", dma_active, 1'b0);
    check("reset_oam_wr", oam_wr, 1'b0);
    check("reset_oam_a", oam_a, 8'h00);
    check("reset_oam_dout", oam_dout, 8'h00);
    tick(); rst = 1'b0;
    repeat (8) tick();

    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_a = vecs[i].a; cpu_dout = vecs[i].dout; cpu_rd = vecs[i].rd; cpu_wr = vecs[i].wr;
      @(negedge clk);
      check($sformatf("idle%0d_mem_a", i), mem_a, vecs[i].exp_a);
      check($sformatf("idle%0d_mem_rd", i), mem_rd, vecs[i].exp_rd);
      check($sformatf("idle%0d_mem_wr", i), mem_wr, vecs[i].exp_wr);
      check($sformatf("idle%0d_cpu_din", i), cpu_din, vecs[i].exp_din);
      check($sformatf("idle%0d_mem_dout", i), mem_dout, vecs[i].exp_dout);
    end

    // Transfer from C1 with blocked / HRAM CPU accesses in the middle.
    clr_mon();
    ff46_write(8'hC1, 0, cw);
    goto(cw + 10 * 4 + 1);
    cpu_rd = 1'b1; cpu_a = 16'h8000;
    @(negedge clk);
    check("active_rd_8000_din", cpu_din, 8'hFF);
    goto(cw + 10 * 4 + 2);
    cpu_wr = 1'b1; cpu_a = 16'hC000; cpu_dout = 8'h42;
    @(negedge clk);
    check("active_wr_c000_blocked", mem_wr, 1'b0);
    goto(cw + 10 * 4 + 3);
    cpu_rd = 1'b1; cpu_a = 16'hFF90;
    @(negedge clk);
    check("active_t3_hram_addr", mem_a, 16'hFF90);
    check("active_t3_hram_rd", mem_rd, 1'b1);
    check("active_t3_hram_din", cpu_din, 8'h77);
    goto(cw + 166 * 4);
    verify("c1", 8'hC1, cw);

    // Source in the E0-FF range folds down by 0x20.
    clr_mon();
    ff46_write(8'hE3, 0, cw);
    goto(cw + 166 * 4);
    verify("e3", 8'hE3, cw);

    // Restart at idx 80 with a new source, written in T1.
    clr_mon();
    ff46_write(8'hC1, 0, cw);
    goto(cw + 82 * 4);
    ff46_write(8'hC2, 1, cw2);
    check("restart_prior_oam_wr", oam_cnt, 80);
    clr_mon();
    goto(cw2 + 170 * 4);
    verify("restart", 8'hC2, cw2 - 1);

    // Random sources with random CPU traffic.
    for (int k = 0; k < 2; k++) begin
      s = 8'($urandom_range(0, 255));
      clr_mon();
      ff46_write(s, 0, cw);
      while (cyc < cw + 166 * 4) begin
        tick();
        rnd_cpu(cw);
      end
      verify($sformatf("rnd%0d", k), s, cw);
    end

    // Reset at idx 40 aborts the transfer.
    clr_mon();
    ff46_write(8'hC1, 0, cw);
    goto(cw + 42 * 4 + 1);
    rst = 1'b1;
    check("rst_prior_oam_wr", oam_cnt, 40);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_dma_active", dma_active, 1'b0);
    check("rst_oam_wr", oam_wr, 1'b0);
    act_base = act_t0;
    repeat (30 * 4) tick();
    check("rst_no_more_oam_wr", oam_cnt, 40);
    check("rst_stays_idle", act_t0, act_base);
    tick();
    cpu_rd = 1'b1; cpu_a = 16'hFF46;
    @(negedge clk);
`ifdef OAM_DMA_READBACK_EN
    check("rst_ff46_read", cpu_din, 8'hFF);
`else
    check("rst_ff46_read", cpu_din, mem[16'hFF46]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
